// File: rtl/safety_limit_commit_ctrl_if.sv
// Host/monitor-side bundle for safety_limit_commit_ctrl: shadow write port,
// commit handshake, armed status and the live limit set with commit status.
interface safety_limit_commit_ctrl_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit_req;
  logic        armed;
  logic [31:0] pulse_width_lower_limit;
  logic [31:0] pulse_width_upper_limit;
  logic [31:0] rate_lower_limit;
  logic [15:0] drive_current_limit;
  logic        commit_busy;
  logic        commit_done;
  logic        commit_err;
  logic [1:0]  err_code;
  logic        wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, commit_req, armed,
    input  pulse_width_lower_limit, pulse_width_upper_limit, rate_lower_limit,
           drive_current_limit, commit_busy, commit_done, commit_err, err_code, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit_req, armed,
    output pulse_width_lower_limit, pulse_width_upper_limit, rate_lower_limit,
           drive_current_limit, commit_busy, commit_done, commit_err, err_code, wr_drop
  );
endinterface

// File: rtl/safety_limit_commit_ctrl.sv
// Validates a host-written shadow limit set and commits it atomically while disarmed.
// Optional WAIT_SAFE abort timer enabled by defining COMMIT_TIMEOUT_EN.
module safety_limit_commit_ctrl #(
  parameter logic [15:0] MAX_DRIVE      = 16'h0FFF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] DEF_PW_LOWER   = 32'd0,
  parameter logic [31:0] DEF_PW_UPPER   = 32'd0,
  parameter logic [31:0] DEF_RATE_LOWER = 32'd0,
  parameter logic [15:0] DEF_DRIVE      = 16'd0
) (
  input logic                      clk,
  input logic                      rstn,
  safety_limit_commit_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_SAFE, CHECK, APPLY} state_t;

  state_t      state, state_nxt;
  logic        load_active, done_nxt, err_nxt;
  logic [1:0]  err_code_nxt;
  logic        wr_ok;

  logic [31:0] sh_pw_lower, sh_pw_upper, sh_rate_lower;
  logic [15:0] sh_drive;
  logic [31:0] act_pw_lower, act_pw_upper, act_rate_lower;
  logic [15:0] act_drive;

  logic        busy_p1, done_p1, err_p1, drop_p1;
  logic [1:0]  err_code_p1;

`ifdef COMMIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  logic             clr_cnt;
`endif

  assign wr_ok = bus.wr_en && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_active  = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    err_code_nxt = err_code_p1;
`ifdef COMMIT_TIMEOUT_EN
    clr_cnt      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.commit_req) begin
          err_code_nxt = 2'd0;
          if (bus.armed) begin
            state_nxt = WAIT_SAFE;
`ifdef COMMIT_TIMEOUT_EN
            clr_cnt   = 1'b1;
`endif
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      WAIT_SAFE: begin
        if (!bus.armed) begin
          state_nxt = CHECK;
        end
`ifdef COMMIT_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          state_nxt    = IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = 2'd3;
        end
`endif
      end
      // Ordering bound first so an inverted window reports as such even if drive is also bad.
      CHECK: begin
        if (sh_pw_lower > sh_pw_upper) begin
          state_nxt    = IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = 2'd1;
        end else if (sh_drive > MAX_DRIVE) begin
          state_nxt    = IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = 2'd2;
        end else begin
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        if (bus.armed) begin
          state_nxt = WAIT_SAFE;
        end else begin
          state_nxt   = IDLE;
          load_active = 1'b1;
          done_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef COMMIT_TIMEOUT_EN
  // Re-entry from APPLY keeps counting so repeated arm glitches cannot extend the wait.
  always_ff @(posedge clk) begin
    if (!rstn)                   cnt <= '0;
    else if (clr_cnt)            cnt <= '0;
    else if (state == WAIT_SAFE) cnt <= cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_pw_lower    <= DEF_PW_LOWER;
      sh_pw_upper    <= DEF_PW_UPPER;
      sh_rate_lower  <= DEF_RATE_LOWER;
      sh_drive       <= DEF_DRIVE;
      act_pw_lower   <= DEF_PW_LOWER;
      act_pw_upper   <= DEF_PW_UPPER;
      act_rate_lower <= DEF_RATE_LOWER;
      act_drive      <= DEF_DRIVE;
    end else begin
      if (wr_ok) begin
        case (bus.wr_addr)
          2'd0:    sh_pw_lower   <= bus.wr_data;
          2'd1:    sh_pw_upper   <= bus.wr_data;
          2'd2:    sh_rate_lower <= bus.wr_data;
          default: sh_drive      <= bus.wr_data[15:0];
        endcase
      end
      if (load_active) begin
        act_pw_lower   <= sh_pw_lower;
        act_pw_upper   <= sh_pw_upper;
        act_rate_lower <= sh_rate_lower;
        act_drive      <= sh_drive;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_p1     <= 1'b0;
      done_p1     <= 1'b0;
      err_p1      <= 1'b0;
      drop_p1     <= 1'b0;
      err_code_p1 <= 2'd0;
    end else begin
      busy_p1     <= (state_nxt != IDLE);
      done_p1     <= done_nxt;
      err_p1      <= err_nxt;
      drop_p1     <= bus.wr_en && (state != IDLE);
      err_code_p1 <= err_code_nxt;
    end
  end

  assign bus.pulse_width_lower_limit = act_pw_lower;
  assign bus.pulse_width_upper_limit = act_pw_upper;
  assign bus.rate_lower_limit        = act_rate_lower;
  assign bus.drive_current_limit     = act_drive;
  assign bus.commit_busy             = busy_p1;
  assign bus.commit_done             = done_p1;
  assign bus.commit_err              = err_p1;
  assign bus.err_code                = err_code_p1;
  assign bus.wr_drop                 = drop_p1;

endmodule

// File: tb/tb_safety_limit_commit_ctrl.sv
// Directed bench for safety_limit_commit_ctrl: commit, rejection, armed wait,
// armed-in-CHECK retry, reset mid-commit and (with COMMIT_TIMEOUT_EN) timeout.
module tb_safety_limit_commit_ctrl;
  localparam logic [31:0] D_PWL = 32'd10;
  localparam logic [31:0] D_PWU = 32'd20;
  localparam logic [31:0] D_RAT = 32'd30;
  localparam logic [15:0] D_DRV = 16'd40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  safety_limit_commit_ctrl_if bus();

  safety_limit_commit_ctrl #(
    .MAX_DRIVE(16'h0FFF), .TIMEOUT_CYCLES(20),
    .DEF_PW_LOWER(D_PWL), .DEF_PW_UPPER(D_PWU),
    .DEF_RATE_LOWER(D_RAT), .DEF_DRIVE(D_DRV)
  ) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pl, input logic [31:0] pu,
                         input logic [31:0] rt, input logic [15:0] dv);
    chk({tag, ".pwl"}, bus.pulse_width_lower_limit, pl);
    chk({tag, ".pwu"}, bus.pulse_width_upper_limit, pu);
    chk({tag, ".rate"}, bus.rate_lower_limit, rt);
    chk({tag, ".drv"}, {16'd0, bus.drive_current_limit}, {16'd0, dv});
  endtask

  task automatic commit();
    bus.commit_req = 1'b1;
    step();
    bus.commit_req = 1'b0;
  endtask

  initial begin
    int n;
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 32'd0;
    bus.commit_req = 1'b0; bus.armed = 1'b0;

    // Reset values
    step(); step();
    chk_out("rst", D_PWL, D_PWU, D_RAT, D_DRV);
    chk("rst.busy", bus.commit_busy, 0);
    chk("rst.done", bus.commit_done, 0);
    chk("rst.err", bus.commit_err, 0);
    chk("rst.code", bus.err_code, 0);
    chk("rst.drop", bus.wr_drop, 0);
    rstn = 1'b1;
    step();

    // Basic commit: outputs change at k+2
    wr(2'd0, 32'd100); wr(2'd1, 32'd200); wr(2'd2, 32'd5000); wr(2'd3, 32'h0800);
    commit();
    chk("c1.busy_k", bus.commit_busy, 1);
    chk_out("c1.k", D_PWL, D_PWU, D_RAT, D_DRV);
    step();
    chk_out("c1.k1", D_PWL, D_PWU, D_RAT, D_DRV);
    chk("c1.done_k1", bus.commit_done, 0);
    step();
    chk_out("c1.k2", 100, 200, 5000, 16'h0800);
    chk("c1.done_k2", bus.commit_done, 1);
    chk("c1.code", bus.err_code, 0);
    step();
    chk("c1.done_off", bus.commit_done, 0);
    chk("c1.busy_off", bus.commit_busy, 0);

    // pw_lower > pw_upper rejected
    wr(2'd0, 32'd300);
    commit(); step();
    chk("e1.err", bus.commit_err, 1);
    chk("e1.code", bus.err_code, 1);
    chk_out("e1", 100, 200, 5000, 16'h0800);
    step();
    chk("e1.err_off", bus.commit_err, 0);
    chk("e1.code_hold", bus.err_code, 1);
    chk("e1.busy", bus.commit_busy, 0);

    // drive above MAX_DRIVE rejected
    wr(2'd0, 32'd50); wr(2'd3, 32'h1000);
    commit(); step();
    chk("e2.err", bus.commit_err, 1);
    chk("e2.code", bus.err_code, 2);
    step();
    // both errors: ordering check wins
    wr(2'd0, 32'd300);
    commit(); step();
    chk("e12.code", bus.err_code, 1);
    step();
    // fix; drive written in the same edge as commit_req, upper data bits ignored
    wr(2'd0, 32'd100);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 32'hFFFF_0FFF;
    commit();
    bus.wr_en = 1'b0;
    chk("c2.code_clr", bus.err_code, 0);
    step(); step();
    chk("c2.done", bus.commit_done, 1);
    chk("c2.err", bus.commit_err, 0);
    chk_out("c2", 100, 200, 5000, 16'h0FFF);
    step();

`ifndef COMMIT_TIMEOUT_EN
    // Armed at commit: wait, dropped write, then complete after disarm
    wr(2'd2, 32'd7777);
    bus.armed = 1'b1;
    commit();
    chk("w.busy", bus.commit_busy, 1);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) bus.wr_en = 1'b1;
      bus.wr_addr = 2'd2; bus.wr_data = 32'd9999;
      if (i == 20) bus.commit_req = 1'b1;
      step();
      bus.wr_en = 1'b0; bus.commit_req = 1'b0;
      if (i == 10) chk("w.drop", bus.wr_drop, 1);
      if (i == 11) chk("w.drop_off", bus.wr_drop, 0);
      if (i == 21) chk("w.ign_err", bus.commit_err, 0);
    end
    chk("w.busy50", bus.commit_busy, 1);
    chk_out("w.hold", 100, 200, 5000, 16'h0FFF);
    bus.armed = 1'b0;
    step(); step();
    chk("w.done_j1", bus.commit_done, 0);
    step();
    chk("w.done_j2", bus.commit_done, 1);
    chk_out("w.j2", 100, 200, 7777, 16'h0FFF);
    step();
`else
    wr(2'd2, 32'd7777);
`endif

    // armed rises during CHECK: APPLY bounces back to WAIT_SAFE
    wr(2'd1, 32'd250);
    commit();
    bus.armed = 1'b1;
    step(); step();
    chk("a.done", bus.commit_done, 0);
    chk("a.busy", bus.commit_busy, 1);
`ifndef COMMIT_TIMEOUT_EN
    chk_out("a.hold", 100, 200, 7777, 16'h0FFF);
`else
    chk_out("a.hold", 100, 200, 5000, 16'h0FFF);
`endif
    bus.armed = 1'b0;
    step(); step(); step();
    chk("a.done2", bus.commit_done, 1);
    chk_out("a.fin", 100, 250, 7777, 16'h0FFF);
    step();

    // Reset during APPLY
    wr(2'd3, 32'h0555);
    commit(); step();
    rstn = 1'b0;
    step();
    chk_out("ra", D_PWL, D_PWU, D_RAT, D_DRV);
    chk("ra.done", bus.commit_done, 0);
    chk("ra.busy", bus.commit_busy, 0);
    rstn = 1'b1;
    step();
    chk("ra.done2", bus.commit_done, 0);
    chk("ra.busy2", bus.commit_busy, 0);

`ifdef COMMIT_TIMEOUT_EN
    // Timeout after 20 cycles in WAIT_SAFE
    wr(2'd3, 32'h0111);
    bus.armed = 1'b1;
    commit();
    n = 0;
    while (!bus.commit_err && n < 40) begin
      step();
      n++;
    end
    chk("t.cycles", n, 20);
    chk("t.code", bus.err_code, 3);
    chk_out("t", D_PWL, D_PWU, D_RAT, D_DRV);
    bus.armed = 1'b0;
    step();
    chk("t.busy", bus.commit_busy, 0);
`else
    n = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
